// File: rtl/round_sequencer.sv
// round_sequencer
// Stores a short sequence of prompt codes, plays it back one prompt per tick
// (each prompt followed by a blank slot of equal length), then collects user
// actions and compares them against the stored sequence.
//
// Parameters
//   DEPTH          maximum sequence length in prompts
//   TICK_DIV       clock cycles per prompt tick (2 or more)
//   TIMEOUT_TICKS  ticks allowed between user actions while collecting
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-low reset
//   start        begin a round (level-sampled in IDLE)
//   append       append append_code to the sequence (IDLE only)
//   append_code  prompt code: 0 toggle, 1 push, 2 mic, 3 mouse
//   clear        empty the sequence (IDLE only)
//   user_valid   single-cycle user action strobe (COLLECT only)
//   user_code    user action code
//   prompt       displayed prompt: 0 none, otherwise code+1
//   busy         high in every state except IDLE
//   done         one-cycle round-complete pulse
//   pass         round result, qualified by done
//   length       current sequence length
module round_sequencer #(
    parameter int DEPTH         = 16,
    parameter int TICK_DIV      = 25000000,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       append,
    input  logic [1:0] append_code,
    input  logic       clear,
    input  logic       user_valid,
    input  logic [1:0] user_code,
    output logic [2:0] prompt,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] length
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam int OW = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [4:0]    DEPTH_L     = 5'(DEPTH);
    localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV - 1);
    localparam logic [OW-1:0] TIMEOUT_L   = OW'(TIMEOUT_TICKS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHOW_ON  = 3'd1,
        SHOW_OFF = 3'd2,
        COLLECT  = 3'd3,
        RESULT   = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [4:0]    len_reg, len_next;
    logic [4:0]    index_reg, index_next;
    logic [TW-1:0] tick_reg, tick_next;
    logic [OW-1:0] timeout_reg, timeout_next;
    logic          pass_reg, pass_next;
    logic          mem_we;

    logic [1:0] mem [DEPTH];

    logic       tick;
    logic       last;
    logic [1:0] cur_code;

    assign tick     = (tick_reg == '0);
    assign last     = (index_reg == len_reg - 5'd1);
    assign cur_code = mem[index_reg[AW-1:0]];
    assign length   = len_reg;

    // Sequence storage; contents survive reset and clear, only length moves.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[len_reg[AW-1:0]] <= append_code;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            index_reg   <= '0;
            tick_reg    <= '0;
            timeout_reg <= '0;
            pass_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            index_reg   <= index_next;
            tick_reg    <= tick_next;
            timeout_reg <= timeout_next;
            pass_reg    <= pass_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        index_next   = index_reg;
        tick_next    = tick_reg;
        timeout_next = timeout_reg;
        pass_next    = pass_reg;
        mem_we       = 1'b0;

        case (state_reg)
            IDLE: begin
                // start wins over clear, which wins over append
                if (start) begin
                    if (len_reg == 5'd0) begin
                        state_next = RESULT;
                        pass_next  = 1'b0;
                    end else begin
                        state_next = SHOW_ON;
                        index_next = '0;
                        tick_next  = TICK_RELOAD;
                    end
                end else if (clear) begin
                    len_next = '0;
                end else if (append && (len_reg < DEPTH_L)) begin
                    mem_we   = 1'b1;
                    len_next = len_reg + 5'd1;
                end
            end

            SHOW_ON: begin
                tick_next = tick ? TICK_RELOAD : tick_reg - TW'(1);
                if (tick) begin
                    state_next = SHOW_OFF;
                end
            end

            SHOW_OFF: begin
                tick_next = tick ? TICK_RELOAD : tick_reg - TW'(1);
                if (tick) begin
                    if (!last) begin
                        index_next = index_reg + 5'd1;
                        state_next = SHOW_ON;
                    end else begin
                        index_next   = '0;
                        timeout_next = '0;
                        state_next   = COLLECT;
                    end
                end
            end

            COLLECT: begin
                // A user action in the same cycle as a tick swallows the tick.
                if (user_valid) begin
                    tick_next    = TICK_RELOAD;
                    timeout_next = '0;
                    if (user_code != cur_code) begin
                        state_next = RESULT;
                        pass_next  = 1'b0;
                    end else if (last) begin
                        state_next = RESULT;
                        pass_next  = 1'b1;
                    end else begin
                        index_next = index_reg + 5'd1;
                    end
                end else begin
                    tick_next = tick ? TICK_RELOAD : tick_reg - TW'(1);
                    if (tick) begin
                        if (timeout_reg + OW'(1) == TIMEOUT_L) begin
                            state_next = RESULT;
                            pass_next  = 1'b0;
                        end else begin
                            timeout_next = timeout_reg + OW'(1);
                        end
                    end
                end
            end

            RESULT: begin
                state_next = IDLE;
                pass_next  = 1'b0;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        prompt = 3'd0;
        if (state_reg == SHOW_ON) begin
            prompt = {1'b0, cur_code} + 3'd1;
        end
        busy = (state_reg != IDLE);
        done = (state_reg == RESULT);
        pass = (state_reg == RESULT) && pass_reg;
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed testbench for round_sequencer with TICK_DIV=4, TIMEOUT_TICKS=3.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_round_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       append;
    logic [1:0] append_code;
    logic       clear;
    logic       user_valid;
    logic [1:0] user_code;
    logic [2:0] prompt;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] length;

    int n_checks = 0;
    int n_fail   = 0;

    round_sequencer #(
        .DEPTH(16),
        .TICK_DIV(4),
        .TIMEOUT_TICKS(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .append(append),
        .append_code(append_code),
        .clear(clear),
        .user_valid(user_valid),
        .user_code(user_code),
        .prompt(prompt),
        .busy(busy),
        .done(done),
        .pass(pass),
        .length(length)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_append(input logic [1:0] code);
        append      = 1'b1;
        append_code = code;
        step();
        append      = 1'b0;
    endtask

    task automatic do_user(input logic [1:0] code);
        user_valid = 1'b1;
        user_code  = code;
        step();
        user_valid = 1'b0;
    endtask

    // Expected playback for sequence 1,3,0: prompt values in 4-cycle slots
    logic [2:0] play_exp [6] = '{3'd2, 3'd0, 3'd4, 3'd0, 3'd1, 3'd0};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; start = 1'b0; append = 1'b0; append_code = 2'd0;
        clear = 1'b0; user_valid = 1'b0; user_code = 2'd0;
        step(); step();
        check_eq("rst_prompt", 32'(prompt), 32'd0);
        check_eq("rst_busy",   32'(busy),   32'd0);
        check_eq("rst_done",   32'(done),   32'd0);
        check_eq("rst_pass",   32'(pass),   32'd0);
        check_eq("rst_length", 32'(length), 32'd0);
        reset = 1'b1;
        step();

        // Load sequence 1,3,0 and play it back
        do_append(2'd1); do_append(2'd3); do_append(2'd0);
        check_eq("load_length", 32'(length), 32'd3);
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 24; k++) begin
            check_eq($sformatf("play_prompt_%0d", k), 32'(prompt), 32'(play_exp[k/4]));
            check_eq($sformatf("play_busy_%0d", k), 32'(busy), 32'd1);
            step();
        end
        check_eq("collect_busy",   32'(busy),   32'd1);
        check_eq("collect_prompt", 32'(prompt), 32'd0);

        // Correct answer
        do_user(2'd1);
        check_eq("ok_done_mid1", 32'(done), 32'd0);
        do_user(2'd3);
        check_eq("ok_done_mid2", 32'(done), 32'd0);
        do_user(2'd0);
        check_eq("ok_done", 32'(done), 32'd1);
        check_eq("ok_pass", 32'(pass), 32'd1);
        step();
        check_eq("ok_idle_busy", 32'(busy),   32'd0);
        check_eq("ok_idle_done", 32'(done),   32'd0);
        check_eq("ok_idle_pass", 32'(pass),   32'd0);
        check_eq("ok_length",    32'(length), 32'd3);

        // Wrong answer on second action
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 24; k++) step();
        do_user(2'd1);
        do_user(2'd2);
        check_eq("bad_done", 32'(done), 32'd1);
        check_eq("bad_pass", 32'(pass), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            check_eq($sformatf("bad_after_prompt_%0d", k), 32'(prompt), 32'd0);
            check_eq($sformatf("bad_after_busy_%0d", k), 32'(busy), 32'd0);
        end

        // Timeout: 3 ticks of 4 cycles with no user action
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 24; k++) step();
        for (int k = 0; k < 11; k++) begin
            step();
            check_eq($sformatf("to_wait_done_%0d", k), 32'(done), 32'd0);
        end
        step();
        check_eq("to_done", 32'(done), 32'd1);
        check_eq("to_pass", 32'(pass), 32'd0);
        step();

        // Empty sequence; start held across RESULT->IDLE restarts a round
        clear = 1'b1; step(); clear = 1'b0;
        check_eq("clr_length", 32'(length), 32'd0);
        start = 1'b1;
        step();
        check_eq("empty_done",   32'(done),   32'd1);
        check_eq("empty_pass",   32'(pass),   32'd0);
        check_eq("empty_prompt", 32'(prompt), 32'd0);
        step();
        check_eq("held_idle_done", 32'(done), 32'd0);
        step();
        check_eq("held_restart_done", 32'(done), 32'd1);
        start = 1'b0;
        step();

        // Fill to DEPTH, overflow ignored, clear beats append
        for (int k = 0; k < 16; k++) do_append(2'(k));
        check_eq("full_length", 32'(length), 32'd16);
        do_append(2'd2);
        check_eq("overflow_length", 32'(length), 32'd16);
        clear = 1'b1; append = 1'b1; append_code = 2'd1;
        step();
        clear = 1'b0; append = 1'b0;
        check_eq("clr_app_length", 32'(length), 32'd0);

        // append/clear ignored while busy, then reset mid-SHOW_ON
        do_append(2'd2);
        start = 1'b1; step(); start = 1'b0;
        check_eq("show_prompt", 32'(prompt), 32'd3);
        clear = 1'b1; step(); clear = 1'b0;
        check_eq("busy_clear_length", 32'(length), 32'd1);
        reset = 1'b0; step(); reset = 1'b1;
        check_eq("midrst_prompt", 32'(prompt), 32'd0);
        check_eq("midrst_busy",   32'(busy),   32'd0);
        check_eq("midrst_length", 32'(length), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
